input_debouncer: RTL
====================

// Module: input_debouncer
// PURPOSE
//  Conditions one raw asynchronous input (push-button or switch) before it reaches the D_FF data input
//  and the ALU operand/opcode registers.
//  It synchronises the input, rejects bounce shorter than STABLE_CYCLES qualifying samples, and outputs
//  a clean level plus one-cycle rise/fall pulses. Sampling can be throttled by an external enable
//  (for example a Clk_div tick).
// PARAMETERS
//  STABLE_CYCLES  4   qualifying samples the synchronised input must hold before Q changes; legal range >= 1
//  CNT_W          $clog2(STABLE_CYCLES+1)   width of the stability counter; derived, not overridden
//  RESET_LEVEL    1'b0  value of Q and of the synchroniser flops during reset
// PORTS
//  Clk        in   1  system clock; all state updates on rising edge
//  Reset_n    in   1  asynchronous, active-low reset
//  D_raw      in   1  raw asynchronous input
//  Sample_en  in   1  qualifying-sample strobe; tie to 1 for a per-clock sample
//  Q          out  1  debounced level; feeds D_FF.D
//  Rise       out  1  one-cycle pulse in the cycle Q goes 0->1
//  Fall       out  1  one-cycle pulse in the cycle Q goes 1->0
//  Busy       out  1  high while a candidate transition is pending
// BEHAVIOUR
//  Reset: Reset_n low forces the following values immediately, independent of Clk:
//   - sync[1:0]=RESET_LEVEL; Q=RESET_LEVEL.
//   - state=STABLE_HI if RESET_LEVEL is 1, otherwise STABLE_LO.
//   - cnt=0; Rise=Fall=Busy=0.
//  Reset mid-pending: the pending transition is abandoned and no pulse is emitted.
//  Synchroniser: 2 flops, sync[0]<=D_raw and sync[1]<=sync[0]. The FSM sees only raw_s=sync[1].
//  FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
//   - STABLE_LO, raw_s==1: go to PEND_HI, cnt<=0. The entry cycle is not a qualifying sample.
//   - PEND_HI, raw_s==0: go to STABLE_LO, cnt<=0, no pulse (bounce reject). This check takes priority
//     over Sample_en.
//   - PEND_HI, raw_s==1, Sample_en==1, cnt<STABLE_CYCLES-1: cnt<=cnt+1.
//   - PEND_HI, raw_s==1, Sample_en==1, cnt==STABLE_CYCLES-1: go to STABLE_HI, Q<=1, Rise<=1 for one cycle, cnt<=0.
//   - PEND_HI, Sample_en==0, raw_s==1: hold state and cnt.
//   - STABLE_HI and PEND_LO mirror the above, with Q<=0 and Fall pulsing.
//  Busy=1 exactly in PEND_HI and PEND_LO. Q, Rise and Fall are registered outputs.
//  Latency (Sample_en=1, clean edge):
//   - Let edge k be the first edge where sync[0] captures the new level.
//   - PEND is entered at edge k+2; Q and the pulse update at edge k+2+STABLE_CYCLES.
//  Rise and Fall are never high together. Pulses never repeat without an intervening opposite transition.
//  cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
//  STABLE_CYCLES==1: the first qualifying sample after PEND entry commits the transition.
// STRUCTURE
//  debounce_pkg:
//   - typedef enum logic [1:0] {STABLE_LO=2'd0, PEND_HI=2'd1, STABLE_HI=2'd2, PEND_LO=2'd3} db_state_t.
//   - Shared with any future multi-button input bank.
//  Sub-module sync_2ff (Clk, Reset_n, d, q; reset value parameter) for the synchroniser; it is reused
//  for other async inputs.
//  All remaining logic lives in one FSM plus counter always block, with registered outputs.
// TESTING
//  1. Reset_n=0 with RESET_LEVEL=0 -> Q=0, Rise=Fall=Busy=0 immediately. Release with D_raw=0 -> no activity for 20 cycles.
//  2. STABLE_CYCLES=4, Sample_en=1, D_raw 0->1 clean:
//     - Q=1 and Rise=1 for exactly one cycle at edge k+6.
//     - Busy is high from edge k+2 through edge k+5.
//  3. D_raw pulses high for 3 cycles, then returns low (STABLE_CYCLES=4) -> Busy toggles, Q stays 0, no Rise.
//  4. Sample_en high every 3rd cycle, D_raw held 1 -> Q rises after 4 Sample_en pulses following PEND entry;
//     cnt holds between strobes.
//  5. Q=1 steady, then D_raw 1->0 with 2 bounces of 1 cycle each -> exactly one Fall pulse, once raw_s is
//     stable for 4 samples.
//  6. Reset_n asserted with PEND_HI at cnt=2 -> Q=0 and Busy=0 asynchronously; no Rise after release if D_raw=0.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding shared by single inputs and future multi-button banks
package debounce_pkg;
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sync_q <= {2{RESET_VAL}};
    else          sync_q <= {sync_q[0], d};
  end
  assign q = sync_q[1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronise, debounce and edge-detect one raw asynchronous input
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic D_raw,
  input  logic Sample_en,
  output logic Q,
  output logic Rise,
  output logic Fall,
  output logic Busy
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam db_state_t RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  logic raw_s;
  db_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic q_q, q_d, rise_q, rise_d, fall_q, fall_d;
  sync_2ff #(.RESET_VAL(RESET_LEVEL)) u_sync (
    .Clk(Clk), .Reset_n(Reset_n), .d(D_raw), .q(raw_s)
  );
  // A level mismatch opens a pending window; a return to the old level inside it is bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: if (raw_s) begin
        state_d = PEND_HI;
        cnt_d   = '0;
      end
      STABLE_HI: if (!raw_s) begin
        state_d = PEND_LO;
        cnt_d   = '0;
      end
      PEND_HI: if (!raw_s) begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end else if (Sample_en) begin
        if (cnt_q == LAST) begin
          state_d = STABLE_HI;
          q_d     = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      PEND_LO: if (raw_s) begin
        state_d = STABLE_HI;
        cnt_d   = '0;
      end else if (Sample_en) begin
        if (cnt_q == LAST) begin
          state_d = STABLE_LO;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = RST_STATE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      q_q     <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign Q    = q_q;
  assign Rise = rise_q;
  assign Fall = fall_q;
  assign Busy = (state_q == PEND_HI) || (state_q == PEND_LO);
endmodule
